// File: rtl/pchb_mux_select_arbiter.sv
// Round-robin, packet-locked arbiter that drives the dual-rail SELECT token of a
// two-input PCHB mux and runs the four-phase SELECT/SELECTe handshake against it.
module pchb_mux_select_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int TO_W        = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [1:0] REQ,
  input  logic [1:0] TAIL,
  input  logic       SELECTe,
  output logic [1:0] SELECT,
  output logic [1:0] GRANT,
  output logic       DONE,
  output logic       LOCKED,
  output logic       ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RTZ   = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ack_s;
  logic [1:0]             select_reg, select_next;
  logic [1:0]             grant_reg, grant_next;
  logic                   done_reg, done_next;
  logic                   locked_reg, locked_next;
  logic                   err_reg, err_next;
  logic                   last_winner_reg, last_winner_next;
  logic                   owner_reg, owner_next;
  logic                   winner_reg, winner_next;
  logic                   tail_q_reg, tail_q_next;
  logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
  logic                   win_valid;
  logic                   win_idx;

  // SELECTe is asynchronous to CLK; only the last synchronizer stage is trusted.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], SELECTe};
    end
  end

  assign ack_s = sync_reg[SYNC_STAGES-1];

  // A locked owner is the only candidate; otherwise contention alternates.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 1'b0;
    if (locked_reg) begin
      win_valid = REQ[owner_reg];
      win_idx   = owner_reg;
    end else begin
      case (REQ)
        2'b01: begin
          win_valid = 1'b1;
          win_idx   = 1'b0;
        end
        2'b10: begin
          win_valid = 1'b1;
          win_idx   = 1'b1;
        end
        2'b11: begin
          win_valid = 1'b1;
          win_idx   = ~last_winner_reg;
        end
        default: begin
          win_valid = 1'b0;
          win_idx   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_next       = state_reg;
    select_next      = select_reg;
    grant_next       = grant_reg;
    done_next        = 1'b0;
    locked_next      = locked_reg;
    err_next         = err_reg;
    last_winner_next = last_winner_reg;
    owner_next       = owner_reg;
    winner_next      = winner_reg;
    tail_q_next      = tail_q_reg;
    to_cnt_next      = to_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (ack_s && win_valid) begin
          state_next  = ISSUE;
          select_next = win_idx ? 2'b10 : 2'b01;
          grant_next  = win_idx ? 2'b10 : 2'b01;
          winner_next = win_idx;
          tail_q_next = TAIL[win_idx];
        end
      end
      ISSUE: begin
        if (!ack_s) begin
          state_next  = RTZ;
          select_next = 2'b00;
          done_next   = 1'b1;
        end
      end
      RTZ: begin
        if (ack_s) begin
          state_next = IDLE;
          if (tail_q_reg) begin
            locked_next      = 1'b0;
            grant_next       = 2'b00;
            last_winner_next = winner_reg;
          end else begin
            locked_next = 1'b1;
            owner_next  = winner_reg;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        select_next = 2'b00;
      end
    endcase

    // Phase watchdog: flags a stuck mux but never aborts the handshake.
    if (state_next != state_reg) begin
      to_cnt_next = '0;
    end else if (state_reg != IDLE && to_cnt_reg != '1) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end
    if (ACK_TIMEOUT != 0 && to_cnt_next == TO_W'(ACK_TIMEOUT)) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg       <= IDLE;
      select_reg      <= 2'b00;
      grant_reg       <= 2'b00;
      done_reg        <= 1'b0;
      locked_reg      <= 1'b0;
      err_reg         <= 1'b0;
      last_winner_reg <= 1'b1;
      owner_reg       <= 1'b0;
      winner_reg      <= 1'b0;
      tail_q_reg      <= 1'b0;
      to_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      select_reg      <= select_next;
      grant_reg       <= grant_next;
      done_reg        <= done_next;
      locked_reg      <= locked_next;
      err_reg         <= err_next;
      last_winner_reg <= last_winner_next;
      owner_reg       <= owner_next;
      winner_reg      <= winner_next;
      tail_q_reg      <= tail_q_next;
      to_cnt_reg      <= to_cnt_next;
    end
  end

  assign SELECT = select_reg;
  assign GRANT  = grant_reg;
  assign DONE   = done_reg;
  assign LOCKED = locked_reg;
  assign ERR    = err_reg;

endmodule
